// File: rtl/div_core.sv
// div_core: 32-bit iterative restoring divider for RISC-V DIV/DIVU/REM/REMU.
// Produces unsigned quotient/remainder magnitudes plus the latched operand sign
// flags, the divisor's two's complement and op_div, so a downstream stage can
// apply the sign fixup. Latency is 32 iterations, or 0 for divide-by-zero.
module div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [1:0]      op_div,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] Q,
    output logic [XLEN-1:0] R,
    output logic            Dividend32,
    output logic            Divisor32,
    output logic [XLEN-1:0] Divisor_2C,
    output logic [1:0]      op_div_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [XLEN-1:0] ONE      = XLEN'(1);
    localparam logic [4:0]      LAST_ITR = 5'd31;

    state_t          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN:0]   rem_q, rem_d;      // one extra bit: the trial subtract never overflows
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;      // divisor magnitude
    logic            sgn_a_q, sgn_a_d;
    logic            sgn_b_q, sgn_b_d;
    logic [XLEN-1:0] d2c_q, d2c_d;
    logic [1:0]      op_q, op_d;

    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] quo_sh;

    // Operand magnitudes: negate only for signed ops with a set MSB.
    always_comb begin
        a_mag = (!op_div[0] && dividend[XLEN-1]) ? (~dividend + ONE) : dividend;
        b_mag = (!op_div[0] && divisor[XLEN-1])  ? (~divisor + ONE)  : divisor;
    end

    // One restoring step: shift {rem,quo} left by one bit.
    always_comb begin
        rem_sh = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
        quo_sh = {quo_q[XLEN-2:0], 1'b0};
    end

    // Next-state and datapath update.
    always_comb begin
        // NOTE: every signal gets a hold default first, so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sgn_a_d = sgn_a_q;
        sgn_b_d = sgn_b_q;
        d2c_d   = d2c_q;
        op_d    = op_q;

        case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    op_d    = op_div;
                    sgn_a_d = dividend[XLEN-1];
                    d2c_d   = ~divisor + ONE;
                    dvs_d   = b_mag;
                    cnt_d   = '0;
                    if (divisor == '0) begin
                        // Divide-by-zero: the divisor flag mirrors the dividend flag so
                        // the sign fixup gives quotient -1 and remainder = dividend.
                        sgn_b_d = dividend[XLEN-1];
                        quo_d   = '1;
                        rem_d   = {1'b0, a_mag};
                        state_d = S_DONE;
                    end else begin
                        sgn_b_d = divisor[XLEN-1];
                        quo_d   = a_mag;
                        rem_d   = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    if (rem_sh >= {1'b0, dvs_q}) begin
                        rem_d = rem_sh - {1'b0, dvs_q};
                        quo_d = quo_sh | ONE;
                    end else begin
                        rem_d = rem_sh;
                        quo_d = quo_sh;
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_ITR) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            sgn_a_q <= 1'b0;
            sgn_b_q <= 1'b0;
            d2c_q   <= '0;
            op_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            sgn_a_q <= sgn_a_d;
            sgn_b_q <= sgn_b_d;
            d2c_q   <= d2c_d;
            op_q    <= op_d;
        end
    end

    // Outputs: status decoded from state, results straight from registers.
    always_comb begin
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        Q          = quo_q;
        R          = rem_q[XLEN-1:0];
        Dividend32 = sgn_a_q;
        Divisor32  = sgn_b_q;
        Divisor_2C = d2c_q;
        op_div_out = op_q;
    end

endmodule
